// File: rtl/tmr32_seq_pkg.sv
// Shared types for the EF_TMR32 write sequencer: FSM states, the table entry
// layout and the timer's register map.
package tmr32_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_ACCESS     = 3'd2,
    ST_WAIT_IRQ   = 3'd3,
    ST_CLR_SETUP  = 3'd4,
    ST_CLR_ACCESS = 3'd5
  } state_t;

  localparam int ENTRY_W  = 50;
  localparam int OFF_LSB  = 0;
  localparam int OFF_W    = 16;
  localparam int DATA_LSB = 16;
  localparam int DATA_W   = 32;
  localparam int WAIT_BIT = 48;
  localparam int LAST_BIT = 49;

  // Field order mirrors the raw 50-bit layout, MSB first.
  typedef struct packed {
    logic              last;
    logic              wait_irq;
    logic [DATA_W-1:0] data;
    logic [OFF_W-1:0]  offset;
  } entry_t;

  localparam logic [15:0] REG_TMR     = 16'h0000;
  localparam logic [15:0] REG_RELOAD  = 16'h0004;
  localparam logic [15:0] REG_PR      = 16'h0008;
  localparam logic [15:0] REG_CMPX    = 16'h000C;
  localparam logic [15:0] REG_CMPY    = 16'h0010;
  localparam logic [15:0] REG_CTRL    = 16'h0014;
  localparam logic [15:0] REG_CFG     = 16'h0018;
  localparam logic [15:0] REG_PWM0CFG = 16'h001C;
  localparam logic [15:0] REG_PWM1CFG = 16'h0020;
  localparam logic [15:0] REG_PWMDT   = 16'h0024;
  localparam logic [15:0] REG_IM      = 16'h0F00;
  localparam logic [15:0] REG_MIS     = 16'h0F04;
  localparam logic [15:0] REG_RIS     = 16'h0F08;
  localparam logic [15:0] REG_IC      = 16'h0F0C;

  function automatic logic drives_bus(input state_t s);
    return (s == ST_SETUP) || (s == ST_ACCESS) ||
           (s == ST_CLR_SETUP) || (s == ST_CLR_ACCESS);
  endfunction

  function automatic logic enable_phase(input state_t s);
    return (s == ST_ACCESS) || (s == ST_CLR_ACCESS);
  endfunction

endpackage

// File: rtl/tmr32_seq_tbl.sv
// Descriptor table: DEPTH x 50-bit register file, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module tmr32_seq_tbl
  import tmr32_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];

  // Table write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/tmr32_seq.sv
// tmr32_seq: APB master that replays a table of EF_TMR32 register writes,
// optionally pausing on the timer interrupt and clearing it through IC.
module tmr32_seq
  import tmr32_seq_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [15:0] IC_OFFSET = REG_IC,
  parameter logic [31:0] IC_CLR    = 32'h0000_0007,
  parameter int          TIMEOUT   = 255
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic               tbl_we,
  input  logic [AW-1:0]      tbl_addr,
  input  logic [ENTRY_W-1:0] tbl_wdata,
  input  logic               irq,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        m_PADDR,
  output logic               m_PSEL,
  output logic               m_PENABLE,
  output logic               m_PWRITE,
  output logic [31:0]        m_PWDATA,
  input  logic               m_PREADY,
  input  logic               m_PSLVERR
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t             state_r, state_nx_s;
  logic [AW-1:0]      idx_r, idx_nx_s;
  logic [TW-1:0]      cnt_r;
  logic               stop_r, stop_pend_s;
  logic               cur_wait_r, cur_last_r;
  logic               set_err_s, clr_err_s, done_s, advance_s;
  logic               timeout_s, at_end_s, in_access_s, tbl_wr_s;
  logic [ENTRY_W-1:0] rd_raw_s;
  entry_t             rd_entry_s;

  // The table may only change while the sequencer is idle.
  assign tbl_wr_s = tbl_we && (state_r == ST_IDLE);

  tmr32_seq_tbl #(.DEPTH(DEPTH), .AW(AW)) u_tbl (
    .clk   (PCLK),
    .we    (tbl_wr_s),
    .waddr (tbl_addr),
    .wdata (tbl_wdata),
    .raddr (idx_nx_s),
    .rdata (rd_raw_s)
  );

  assign rd_entry_s  = entry_t'(rd_raw_s);
  assign in_access_s = enable_phase(state_r);
  assign timeout_s   = (cnt_r == TW'(TIMEOUT - 1));
  assign at_end_s    = cur_last_r || (idx_r == AW'(DEPTH - 1));
  assign stop_pend_s = stop_r || stop;

  // Next-state logic, including the shared end-of-entry advance decision
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    set_err_s  = 1'b0;
    clr_err_s  = 1'b0;
    done_s     = 1'b0;
    advance_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_SETUP;
          idx_nx_s   = {AW{1'b0}};
          clr_err_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: state_nx_s = ST_ACCESS;
      ST_ACCESS: begin
        if (m_PREADY) begin
          if (m_PSLVERR) begin
            set_err_s  = 1'b1;
            state_nx_s = ST_IDLE;
          end else if (cur_wait_r) begin
            state_nx_s = ST_WAIT_IRQ;
          end else begin
            advance_s = 1'b1;
          end
        end else if (timeout_s) begin
          set_err_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_ACCESS;
        end
      end
      ST_WAIT_IRQ: begin
        if (stop_pend_s) begin
          state_nx_s = ST_IDLE;
        end else if (irq) begin
          state_nx_s = ST_CLR_SETUP;
        end else begin
          state_nx_s = ST_WAIT_IRQ;
        end
      end
      ST_CLR_SETUP: state_nx_s = ST_CLR_ACCESS;
      ST_CLR_ACCESS: begin
        if (m_PREADY) begin
          if (m_PSLVERR) begin
            set_err_s  = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            advance_s = 1'b1;
          end
        end else if (timeout_s) begin
          set_err_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_CLR_ACCESS;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase

    // A pending stop wins over looping and suppresses done.
    if (advance_s) begin
      if (stop_pend_s) begin
        state_nx_s = ST_IDLE;
      end else if (at_end_s) begin
        if (loop_en) begin
          idx_nx_s   = {AW{1'b0}};
          state_nx_s = ST_SETUP;
        end else begin
          done_s     = 1'b1;
          state_nx_s = ST_IDLE;
        end
      end else begin
        idx_nx_s   = idx_r + AW'(1);
        state_nx_s = ST_SETUP;
      end
    end else begin
      done_s = done_s;
    end
  end

  // FSM state, index, timeout counter, stop flag and status outputs
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r <= ST_IDLE;
      idx_r   <= {AW{1'b0}};
      cnt_r   <= {TW{1'b0}};
      stop_r  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      if (in_access_s && !m_PREADY) begin
        cnt_r <= cnt_r + TW'(1);
      end else begin
        cnt_r <= {TW{1'b0}};
      end
      if (state_nx_s == ST_IDLE) begin
        stop_r <= 1'b0;
      end else if (stop && (state_r != ST_IDLE)) begin
        stop_r <= 1'b1;
      end else begin
        stop_r <= stop_r;
      end
      busy <= (state_nx_s != ST_IDLE);
      done <= done_s;
      if (clr_err_s) begin
        err <= 1'b0;
      end else if (set_err_s) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

  // APB output registers, loaded from the state being entered
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      m_PSEL     <= 1'b0;
      m_PENABLE  <= 1'b0;
      m_PWRITE   <= 1'b0;
      m_PADDR    <= 16'h0000;
      m_PWDATA   <= 32'h0000_0000;
      cur_wait_r <= 1'b0;
      cur_last_r <= 1'b0;
    end else begin
      m_PSEL    <= drives_bus(state_nx_s);
      m_PENABLE <= enable_phase(state_nx_s);
      m_PWRITE  <= drives_bus(state_nx_s);
      if (state_nx_s == ST_SETUP) begin
        m_PADDR    <= rd_entry_s.offset;
        m_PWDATA   <= rd_entry_s.data;
        cur_wait_r <= rd_entry_s.wait_irq;
        cur_last_r <= rd_entry_s.last;
      end else if (state_nx_s == ST_CLR_SETUP) begin
        m_PADDR  <= IC_OFFSET;
        m_PWDATA <= IC_CLR;
      end else begin
        m_PADDR  <= m_PADDR;
        m_PWDATA <= m_PWDATA;
      end
    end
  end

endmodule

// File: tb/tb_tmr32_seq.sv
// Randomized self-checking bench for tmr32_seq: an APB slave model records
// every completed write and compares it with a table-walk reference model.
module tb_tmr32_seq;
  import tmr32_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TMO   = 8;

  logic        PCLK = 1'b0;
  logic        PRESET, start, stop, loop_en, tbl_we, irq;
  logic [AW-1:0] tbl_addr;
  logic [49:0] tbl_wdata;
  logic        busy, done, err;
  logic [15:0] m_PADDR;
  logic        m_PSEL, m_PENABLE, m_PWRITE;
  logic [31:0] m_PWDATA;
  logic        m_PREADY, m_PSLVERR;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // slave model knobs (written by tests) and state (written by the monitor)
  int   ws = 0;
  int   err_at = -1;
  logic stuck = 1'b0;
  int   acc_cnt = 0;
  int   wr_count = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  logic [47:0] obs_q [$];
  int          obs_t [$];
  logic [47:0] exp_q [$];
  logic [49:0] mir [DEPTH];

  tmr32_seq #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .stop(stop), .loop_en(loop_en),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .irq(irq),
    .busy(busy), .done(done), .err(err),
    .m_PADDR(m_PADDR), .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE), .m_PWRITE(m_PWRITE),
    .m_PWDATA(m_PWDATA), .m_PREADY(m_PREADY), .m_PSLVERR(m_PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  assign m_PREADY  = m_PSEL & m_PENABLE & ~stuck & (acc_cnt >= ws);
  assign m_PSLVERR = m_PREADY & (wr_count == err_at);

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (PRESET || !(m_PSEL && m_PENABLE) || m_PREADY) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
    if (!PRESET && m_PSEL && m_PENABLE && m_PREADY) begin
      obs_q.push_back({m_PADDR, m_PWDATA});
      obs_t.push_back(cyc);
      wr_count <= wr_count + 1;
    end
    if (!PRESET && done) done_cnt <= done_cnt + 1;
  end

  // Reference: walk the table from entry 0, IC clear after each wait entry,
  // stop at the last-flagged entry or the end of the table.
  function automatic void build_exp(input int passes);
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_q.push_back({mir[i][15:0], mir[i][47:16]});
        if (mir[i][48]) exp_q.push_back({16'h0F0C, 32'h0000_0007});
        if (mir[i][49]) break;
      end
    end
  endfunction

  task automatic load(input int i, input logic [15:0] off, input logic [31:0] d,
                      input logic w, input logic l);
    tbl_we = 1'b1; tbl_addr = AW'(i); tbl_wdata = {l, w, d, off};
    @(negedge PCLK);
    tbl_we = 1'b0;
    mir[i] = {l, w, d, off};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int used;
    used = 0;
    while (busy && used < limit) begin
      @(negedge PCLK);
      used++;
    end
    @(negedge PCLK);
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    chk_cnt++;
    if ({busy, done, err, m_PSEL, m_PENABLE, m_PWRITE} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, err, m_PSEL, m_PENABLE, m_PWRITE});
    else pass_cnt++;
    chk_cnt++;
    if ({m_PADDR, m_PWDATA} !== 48'h0)
      $display("FAIL reset_bus: got %h want 0", {m_PADDR, m_PWDATA});
    else pass_cnt++;
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_bringup();
    int k;
    obs_q.delete(); obs_t.delete(); ws = 0; loop_en = 1'b0;
    load(0, 16'h0004, 32'd10, 1'b0, 1'b0);
    load(1, 16'h0008, 32'd4,  1'b0, 1'b0);
    load(2, 16'h0018, 32'h7,  1'b0, 1'b0);
    load(3, 16'h0014, 32'h1,  1'b0, 1'b1);
    build_exp(1);
    pulse_start();
    k = 1;
    while (!done && k < 40) begin
      @(negedge PCLK);
      k++;
    end
    chk_cnt++;
    if (k !== 9) $display("FAIL bringup_done_latency: got %0d want 9", k); else pass_cnt++;
    @(negedge PCLK);
    chk_cnt++;
    if ({done, busy, err} !== 3'b000) $display("FAIL bringup_after: got %b want 000", {done, busy, err});
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL bringup_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL bringup_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
    for (int i = 1; i < obs_t.size(); i++) begin
      chk_cnt++;
      if (obs_t[i] - obs_t[i-1] !== 2) $display("FAIL bringup_slot%0d: got %0d want 2", i, obs_t[i] - obs_t[i-1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_irq_wait();
    int d0;
    obs_q.delete(); ws = 0; irq = 1'b0; loop_en = 1'b0;
    load(0, 16'h000C, 32'd3, 1'b1, 1'b0);
    load(1, 16'h000C, 32'd7, 1'b0, 1'b1);
    build_exp(1);
    d0 = done_cnt;
    pulse_start();
    repeat (20) @(negedge PCLK);
    chk_cnt++;
    if ({busy, m_PSEL, 1'b0} !== 3'b100 || obs_q.size() !== 1)
      $display("FAIL irq_waiting: got busy/psel %b%b writes %0d want 10 writes 1", busy, m_PSEL, obs_q.size());
    else pass_cnt++;
    irq = 1'b1;
    @(negedge PCLK);
    chk_cnt++;
    if ({m_PSEL, m_PENABLE, m_PADDR, m_PWDATA} !== {2'b10, 16'h0F0C, 32'h0000_0007})
      $display("FAIL irq_clr_setup: got %b%b %h %h want 10 0f0c 00000007", m_PSEL, m_PENABLE, m_PADDR, m_PWDATA);
    else pass_cnt++;
    irq = 1'b0;
    wait_idle(100);
    chk_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL irq_done: got %0d want 1", done_cnt - d0); else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL irq_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL irq_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int n, d0;
    for (int it = 0; it < 4; it++) begin
      obs_q.delete(); loop_en = 1'b0; irq = 1'b1;
      ws = $urandom_range(0, 2);
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++)
        load(i, 16'($urandom_range(0, 65535)), 32'($urandom()), 1'($urandom_range(0, 1)), (i == n - 1));
      build_exp(1);
      d0 = done_cnt;
      pulse_start();
      wait_idle(500);
      chk_cnt++;
      if ({busy, err} !== 2'b00 || done_cnt - d0 !== 1)
        $display("FAIL rand%0d_status: got busy/err %b%b done %0d want 00 done 1", it, busy, err, done_cnt - d0);
      else pass_cnt++;
      chk_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d", it, obs_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        chk_cnt++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL rand%0d_write%0d: got %h want %h", it, i, obs_q[i], exp_q[i]);
        else pass_cnt++;
      end
    end
    irq = 1'b0; ws = 0;
  endtask

  task automatic test_loop_stop();
    int base, d0, k;
    obs_q.delete(); ws = 0; irq = 1'b0;
    load(0, 16'h000C, 32'($urandom()), 1'b0, 1'b0);
    load(1, 16'h0010, 32'($urandom()), 1'b0, 1'b1);
    build_exp(3);
    loop_en = 1'b1;
    base = wr_count; d0 = done_cnt;
    pulse_start();
    k = 0;
    while (wr_count < base + 4 && k < 100) begin
      @(negedge PCLK);
      k++;
    end
    ws = 3;
    k = 0;
    while (!(m_PSEL && m_PENABLE) && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    stop = 1'b1;
    @(negedge PCLK);
    stop = 1'b0;
    wait_idle(50);
    repeat (3) @(negedge PCLK);
    loop_en = 1'b0; ws = 0;
    chk_cnt++;
    if ({busy, m_PSEL, err} !== 3'b000 || done_cnt !== d0)
      $display("FAIL stop_status: got busy/psel/err %b done %0d want 000 done 0", {busy, m_PSEL, err}, done_cnt - d0);
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== 5) $display("FAIL stop_count: got %0d want 5", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL loop_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_slverr();
    int d0;
    obs_q.delete(); ws = 0; loop_en = 1'b0;
    load(0, 16'h0004, 32'($urandom()), 1'b0, 1'b0);
    load(1, 16'h0008, 32'($urandom()), 1'b0, 1'b0);
    load(2, 16'h0018, 32'($urandom()), 1'b0, 1'b1);
    build_exp(1);
    err_at = wr_count + 1;
    d0 = done_cnt;
    pulse_start();
    wait_idle(50);
    repeat (4) @(negedge PCLK);
    err_at = -1;
    chk_cnt++;
    if ({err, busy} !== 2'b10 || done_cnt !== d0)
      $display("FAIL slverr_status: got err/busy %b%b done %0d want 10 done 0", err, busy, done_cnt - d0);
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== 2) $display("FAIL slverr_count: got %0d want 2", obs_q.size()); else pass_cnt++;
    obs_q.delete();
    pulse_start();
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL slverr_clear: got %b want 0", err); else pass_cnt++;
    wait_idle(50);
    chk_cnt++;
    if (obs_q.size() !== exp_q.size() || done_cnt - d0 !== 1)
      $display("FAIL slverr_rerun: got writes %0d done %0d want %0d done 1", obs_q.size(), done_cnt - d0, exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL slverr_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    int n;
    stuck = 1'b1;
    pulse_start();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!m_PSEL) break;
      if (m_PENABLE) n++;
      @(negedge PCLK);
    end
    stuck = 1'b0;
    chk_cnt++;
    if (n !== TMO) $display("FAIL timeout_cycles: got %0d want %0d", n, TMO); else pass_cnt++;
    chk_cnt++;
    if ({err, busy, m_PSEL} !== 3'b100) $display("FAIL timeout_status: got %b want 100", {err, busy, m_PSEL});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    obs_q.delete(); ws = 3; loop_en = 1'b0;
    load(0, 16'h0024, 32'($urandom()), 1'b0, 1'b0);
    load(1, 16'h001C, 32'($urandom()), 1'b0, 1'b1);
    pulse_start();
    @(negedge PCLK);
    tbl_we = 1'b1; tbl_addr = 4'd0; tbl_wdata = {2'b01, 32'hDEAD_BEEF, 16'h0F00};
    @(negedge PCLK);
    tbl_we = 1'b0;
    PRESET = 1'b1;
    @(negedge PCLK);
    chk_cnt++;
    if ({m_PSEL, m_PENABLE, busy} !== 3'b000) $display("FAIL resetmid_status: got %b want 000", {m_PSEL, m_PENABLE, busy});
    else pass_cnt++;
    PRESET = 1'b0; ws = 0;
    @(negedge PCLK);
    obs_q.delete();
    build_exp(1);
    pulse_start();
    wait_idle(50);
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL resetmid_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL resetmid_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    PRESET = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; tbl_we = 1'b0;
    irq = 1'b0; tbl_addr = 4'd0; tbl_wdata = 50'h0;
    test_reset();
    test_bringup();
    test_irq_wait();
    test_random();
    test_loop_stop();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tmr32_seq.md
# tmr32_seq

Descriptor-driven APB master that sequences an EF_TMR32 timer/PWM instance. It replaces CPU-driven bring-up and cycle-by-cycle PWM updates. Software loads a small table of register writes and starts the sequencer. The block issues the writes on the timer's APB slave port, can pause on the timer interrupt between writes, acknowledges that interrupt through the timer's IC register, and can loop the table. It sits between a configuration host (or fixed ROM loader) and the timer's APB slave port.

## Interface
- DEPTH, 16, number of table entries (power of 2, 2..256)
- AW, $clog2(DEPTH), table index width
- IC_OFFSET, 16'h0F0C, timer interrupt-clear register offset
- IC_CLR, 32'h0000_0007, data written to IC_OFFSET after each interrupt wait
- TIMEOUT, 255, maximum PREADY wait cycles per APB access before error

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset; synchronous to PCLK, active-high
- start  in  1  pulse; begins at entry 0 when idle
- stop  in  1  pulse; requests halt
- loop_en  in  1  after the last entry, restart at entry 0
- tbl_we  in  1  table write strobe
- tbl_addr  in  AW  table write index
- tbl_wdata  in  50  table entry: [15:0] offset, [47:16] data, [48] wait_irq, [49] last
- irq  in  1  timer IRQ, level
- busy  out  1  sequencer active
- done  out  1  one-cycle pulse when the sequence ends normally
- err  out  1  sticky; set on PSLVERR or timeout; cleared by start
- m_PADDR  out  16  APB address
- m_PSEL, m_PENABLE, m_PWRITE  out  1  APB controls; PWRITE is always 1 during transfers
- m_PWDATA  out  32  APB write data
- m_PREADY, m_PSLVERR  in  1  APB response

## Operation
- FSM states: IDLE, SETUP, ACCESS, WAIT_IRQ, CLR_SETUP, CLR_ACCESS.
- **IDLE.** On `start`, the index is cleared, `err` is cleared, and the FSM moves to SETUP.
  - `tbl_we` is accepted only in IDLE. It is ignored while `busy` is high.
  - `start` while busy is ignored.
- **SETUP.** Drives PADDR = entry.offset, PWDATA = entry.data, PSEL=1, PENABLE=0. Always goes to ACCESS.
- **ACCESS.** PSEL=1, PENABLE=1, holding address and data until PREADY.
  - PREADY with PSLVERR: set `err`, go to IDLE. No `done`.
  - PREADY without PSLVERR, entry.wait_irq=1: go to WAIT_IRQ.
  - Otherwise, the entry is complete; apply the advance rule.
- **WAIT_IRQ.** Bus idle. When `irq` is sampled high (level; already high on entry counts), go to CLR_SETUP. CLR_SETUP/CLR_ACCESS perform the write IC_OFFSET <= IC_CLR, with the same error rules as SETUP/ACCESS, then apply the advance rule.
- **Advance rule.**
  - If entry.last=1 or index=DEPTH-1: with loop_en, set index=0 and go to SETUP; otherwise pulse `done` and go to IDLE.
  - Otherwise, increment the index and go to SETUP.
- **stop.**
  - Recorded in a pending flag.
  - Honoured only at an entry boundary (the point where the advance rule would apply) or immediately in WAIT_IRQ.
  - An APB access in progress is never abandoned.
  - A stop ends the sequence in IDLE with no `done` pulse.
- **Timeout.** A counter runs in ACCESS/CLR_ACCESS. On reaching TIMEOUT cycles without PREADY, set `err`, drop PSEL, and go to IDLE.
- **Reset.** PRESET forces IDLE in any state, including mid-transfer. Outputs after reset: busy=0, done=0, err=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0. Table contents are not reset.

## Timing
- All outputs are registered.
- `start` sampled at edge n gives SETUP visible in cycle n+1 and ACCESS in n+2.
- With zero wait states:
  - Consecutive entries take 2 cycles each, back-to-back with no idle cycle.
  - The IC clear begins 1 cycle after `irq` is sampled.
- `busy` is high from the cycle after `start` until the cycle the FSM returns to IDLE.
- `done` pulses in the first IDLE cycle.
- `m_PSEL` is low in IDLE and WAIT_IRQ.

## Structure
- Package `tmr32_seq_pkg`:
  - state enum
  - entry field positions/widths and the entry struct
  - EF_TMR32 register offset constants (TMR 0x00, RELOAD 0x04, PR 0x08, CMPX 0x0C, CMPY 0x10, CTRL 0x14, CFG 0x18, PWM0CFG 0x1C, PWM1CFG 0x20, PWMDT 0x24, IM 0xF00, MIS 0xF04, RIS 0xF08, IC 0xF0C)
- Sub-module `tmr32_seq_tbl`: DEPTH x 50 register file, one write port, one asynchronous read port indexed by the FSM.
- Top level: FSM, index counter, timeout counter, stop flag, APB output registers.

## Test plan
1. **Zero-wait bring-up.** Load 4 entries (RELOAD=10, PR=4, CFG=0x7, CTRL=0x1 with last=1), start, against a zero-wait slave → exactly 4 writes at 0x04, 0x08, 0x18, 0x14 on consecutive 2-cycle slots; `done` pulse 9 cycles after start; busy=0 afterwards.
2. **IRQ wait and clear.** Entry 0 = CMPX=3 with wait_irq, entry 1 = CMPX=7 with last. Assert irq 20 cycles later → write 0xF0C=0x7 one cycle after irq is sampled, then CMPX=7, then `done`.
3. **Loop and stop.** 2-entry table, loop_en=1 → entries repeat 0,1,0,1. Pulse stop during an ACCESS with PREADY held low 3 cycles → that write completes, no new SETUP, busy drops, no `done`.
4. **Slave error.** PSLVERR on entry 1 → err=1, FSM returns to IDLE, entry 2 never issued. Next `start` clears err.
5. **Timeout.** With TIMEOUT=8, PREADY stuck low → err set after 8 ACCESS cycles and PSEL drops.
6. **Reset mid-transfer.** Assert PRESET during ACCESS → next cycle PSEL=PENABLE=busy=0. `tbl_we` while busy leaves the table unchanged, confirmed by readback after restart.
